// File: rtl/conbus_pkg.sv
// Shared definitions for the round-robin shared-bus arbiter: master count,
// grant width, arbiter state encoding and the rotating-priority search.
`default_nettype none

package conbus_pkg;

    localparam int NMASTER = 5;
    localparam int GNT_W   = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    // First requester after cur, wrapping 4->0; returns cur when nobody else asks.
    function automatic logic [GNT_W-1:0] next_owner(
        input logic [GNT_W-1:0]   cur,
        input logic [NMASTER-1:0] req
    );
        int idx;
        next_owner = cur;
        for (int k = NMASTER - 1; k >= 1; k--) begin
            idx = int'(cur) + k;
            if (idx >= NMASTER) idx = idx - NMASTER;
            if (req[idx]) next_owner = GNT_W'(idx);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/conbus_wdt.sv
// Stall watchdog: counts enabled cycles and flags the cycle in which the
// count would reach TIMEOUT_CYCLES, then restarts from zero.
`default_nettype none

module conbus_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Expiry is decided one count early so the counter never holds TIMEOUT_CYCLES.
    assign expired_o = cnt_en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expired_o) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conbus_rrwd_arb.sv
// Round-robin arbiter for a 5-master shared bus with parking and an optional
// stall watchdog, built in when CONBUS_ARB_WATCHDOG_EN is defined.
`default_nettype none

module conbus_rrwd_arb
    import conbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NMASTER-1:0] req,
    input  logic               stb,
    input  logic               ack,
    output logic [GNT_W-1:0]   gnt,
    output logic               err,
    output logic               busy
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("conbus_rrwd_arb: TIMEOUT_CYCLES out of range 2..65535");
    end

    logic [GNT_W-1:0] gnt_q;
    logic [GNT_W-1:0] gnt_d;
    logic             owner_req;
    state_t           state;

    assign owner_req = req[gnt_q];

    // The owner keeps the bus while it holds cyc; otherwise rotate (or park).
    assign gnt_d = owner_req ? gnt_q : next_owner(gnt_q, req);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
        end
    end

`ifdef CONBUS_ARB_WATCHDOG_EN
    logic in_err_q;
    logic in_err_d;
    logic err_q;
    logic wdt_en;
    logic wdt_expired;

    assign state = (sys_rst || !owner_req) ? ST_IDLE :
                   (in_err_q ? ST_ERR : ST_GRANT);

    assign wdt_en = (state == ST_GRANT) && stb && !ack;

    conbus_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .cnt_en_i (wdt_en),
        .clr_i    (!wdt_en),
        .expired_o(wdt_expired)
    );

    // ERR persists only while the offending owner still holds cyc.
    assign in_err_d = owner_req && (in_err_q || wdt_expired);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            in_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            in_err_q <= in_err_d;
            err_q    <= wdt_expired;
        end
    end

    assign err = err_q;
`else
    logic unused_wdt_inputs;

    assign state             = (sys_rst || !owner_req) ? ST_IDLE : ST_GRANT;
    assign err               = 1'b0;
    assign unused_wdt_inputs = &{1'b0, stb, ack};
`endif

    assign gnt  = gnt_q;
    assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conbus_rrwd_arb.sv
// Scoreboard bench for conbus_rrwd_arb: directed scenarios plus random traffic
// compared against a cycle-level reference model of the arbitration rules.
`default_nettype none

module tb_conbus_rrwd_arb;

    localparam int T = 8;
`ifdef CONBUS_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [4:0] req     = '0;
    logic       stb     = 1'b0;
    logic       ack     = 1'b0;
    logic [2:0] gnt;
    logic       err;
    logic       busy;

    conbus_rrwd_arb #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .req    (req),
        .stb    (stb),
        .ack    (ack),
        .gnt    (gnt),
        .err    (err),
        .busy   (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef logic [4:0] exp_t;   // {gnt, busy, err}
    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    int own    = 0;
    bit inerr  = 0;
    int cnt    = 0;
    bit errout = 0;

    task automatic cycle(input logic [4:0] r, input logic s, input logic a, input logic rs);
        exp_t e;
        @(posedge sys_clk);
        #1;
        req = r; stb = s; ack = a; sys_rst = rs;
        if (rs) begin
            own = 0; inerr = 0; cnt = 0; errout = 0;
            e = 5'b0;
        end else begin
            e = {3'(own), r[own], errout};
            if (!r[own]) begin
                inerr = 0; cnt = 0; errout = 0;
                for (int k = 1; k <= 5; k++) begin
                    if (r[(own + k) % 5]) begin
                        own = (own + k) % 5;
                        break;
                    end
                end
            end else begin
                errout = 0;
                if (WD && !inerr && s && !a) begin
                    if (cnt + 1 == T) begin
                        errout = 1; cnt = 0; inerr = 1;
                    end else begin
                        cnt = cnt + 1;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
        expq.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_chk++;
            if ({gnt, busy, err} !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got gnt=%0d busy=%b err=%b expected gnt=%0d busy=%b err=%b",
                         $time, gnt, busy, err, e[4:2], e[1], e[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] r;
        // Reset, then a single master claims the parked grant immediately
        repeat (2) cycle(5'b00000, 1'b0, 1'b0, 1'b1);
        repeat (21) cycle(5'b00001, 1'b0, 1'b0, 1'b0);

        // Rotation 0 -> 1 -> 2 -> 4 -> 1, then wrap 4 -> 0
        repeat (2) cycle(5'b10111, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(5'b10110, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(5'b10100, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(5'b10000, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(5'b00010, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle(5'b10000, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(5'b00011, 1'b0, 1'b0, 1'b0);

        // Stall timeout, then release and hand over
        cycle(5'b00000, 1'b0, 1'b0, 1'b1);
        repeat (12) cycle(5'b00001, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(5'b00010, 1'b0, 1'b0, 1'b0);

        // ack in cycle 7 suppresses the error
        cycle(5'b00000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(5'b00001, 1'b1, (i == 7), 1'b0);

        // stb gap restarts the count
        cycle(5'b00000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(5'b00001, (i != 4), 1'b0, 1'b0);

        // Long stall
        cycle(5'b00000, 1'b0, 1'b0, 1'b1);
        repeat (100) cycle(5'b00001, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while master 3 owns the bus
        repeat (3) cycle(5'b01000, 1'b1, 1'b0, 1'b0);
        cycle(5'b01000, 1'b1, 1'b0, 1'b1);
        #1;
        n_chk++;
        if (gnt !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got gnt=%0d busy=%b err=%b expected gnt=0 busy=0 err=0",
                     gnt, busy, err);
        end
        cycle(5'b01001, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(5'b01001, 1'b0, 1'b0, 1'b0);

        // Random traffic: owner holds longer than others toggle
        r = 5'b01001;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 5; k++) begin
                if (k == own) begin
                    if ($urandom_range(0, 19) == 0) r[k] = ~r[k];
                end else begin
                    if ($urandom_range(0, 4) == 0) r[k] = ~r[k];
                end
            end
            cycle(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 299) == 0));
        end

        repeat (2) @(posedge sys_clk);
        #1;
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
